// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port arbiter in front of a single-beat data memory.
// Each access is IDLE -> ISSUE (-> RWAIT for reads) -> IDLE.
// Optional build macro DMARB_ROUND_ROBIN_EN: on contention, the port that was
// not granted last wins. Without it, p0 always wins contention.
module data_mem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2
    } state_t;

    // Command as latched from the winning port.
    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    state_t       state, state_n;
    logic [1:0]   req;
    logic         win;      // winning port index when any request is present
    logic         accept;   // request sampled this cycle
    cmd_t         sel_cmd;

    assign req = {p1_req, p0_req};

`ifdef DMARB_ROUND_ROBIN_EN
    logic last_winner;

    // Contention goes to the port not granted last; a lone requester always wins.
    always_comb begin
        win = 1'b0;
        if (req == 2'b11)
            win = ~last_winner;
        else
            win = req[1];
    end

    // Remember who was granted; reset to 1 so p0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst)
            last_winner <= 1'b1;
        else if (accept)
            last_winner <= win;
    end
`else
    // Fixed priority: p0 wins whenever it requests.
    assign win = ~p0_req;
`endif

    // Mux the winning port's command fields.
    always_comb begin
        sel_cmd.we    = p0_we;
        sel_cmd.addr  = p0_addr;
        sel_cmd.wdata = p0_wdata;
        if (win) begin
            sel_cmd.we    = p1_we;
            sel_cmd.addr  = p1_addr;
            sel_cmd.wdata = p1_wdata;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    accept  = 1'b1;
                    state_n = ISSUE;
                end
            end
            // mem_write is high in ISSUE exactly when the command is a write.
            ISSUE:   state_n = mem_write ? IDLE : RWAIT;
            RWAIT:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Registered outputs: strobes/grants/rvalid are single-cycle pulses,
    // command and read-data registers hold until overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            p0_gnt    <= 1'b0;
            p1_gnt    <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
            owner     <= 1'b0;
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            p0_gnt    <= 1'b0;
            p1_gnt    <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mem_addr  <= sel_cmd.addr;
                        mem_wdata <= sel_cmd.wdata;
                        mem_write <= sel_cmd.we;
                        mem_read  <= ~sel_cmd.we;
                        p0_gnt    <= ~win;
                        p1_gnt    <= win;
                        owner     <= win;
                    end else begin
                        owner     <= 1'b0;
                    end
                end
                ISSUE: begin
                    // A write is finished once its strobe has gone out.
                    if (mem_write)
                        owner <= 1'b0;
                end
                RWAIT: begin
                    // Memory data is valid now; hand it to the owning port.
                    if (owner) begin
                        p1_rdata  <= mem_rdata;
                        p1_rvalid <= 1'b1;
                    end else begin
                        p0_rdata  <= mem_rdata;
                        p0_rvalid <= 1'b1;
                    end
                end
                default: owner <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a one-cycle-latency memory model.
module tb_data_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [7:0]  p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_read, mem_write, owner;
    logic [31:0] rd_val;

    int errors = 0;
    int checks = 0;

    data_mem_arbiter #(.AW(8), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: returns rd_val one cycle after a read strobe.
    always @(posedge clk) begin
        if (mem_read)
            mem_rdata <= rd_val;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chka(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_w;
        rst = 1'b1;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        rd_val = '0;
        mem_rdata = '0;
        tick();
        tick();

        // Reset state
        chk1("rst_p0_gnt", p0_gnt, 1'b0);
        chk1("rst_p1_gnt", p1_gnt, 1'b0);
        chk1("rst_p0_rvalid", p0_rvalid, 1'b0);
        chk1("rst_p1_rvalid", p1_rvalid, 1'b0);
        chk1("rst_mem_read", mem_read, 1'b0);
        chk1("rst_mem_write", mem_write, 1'b0);
        chk1("rst_owner", owner, 1'b0);
        chka("rst_mem_addr", mem_addr, 8'h00);
        chkd("rst_mem_wdata", mem_wdata, 32'h0);
        chkd("rst_p0_rdata", p0_rdata, 32'h0);
        chkd("rst_p1_rdata", p1_rdata, 32'h0);
        rst = 1'b0;
        tick();
        chk1("idle_no_req_write", mem_write, 1'b0);

        // p0 write 0x04 / DEADBEEF
        p0_req = 1; p0_we = 1; p0_addr = 8'h04; p0_wdata = 32'hDEADBEEF;
        tick();
        chk1("wr_p0_gnt", p0_gnt, 1'b1);
        chk1("wr_p1_gnt", p1_gnt, 1'b0);
        chk1("wr_mem_write", mem_write, 1'b1);
        chk1("wr_mem_read", mem_read, 1'b0);
        chka("wr_mem_addr", mem_addr, 8'h04);
        chkd("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk1("wr_owner", owner, 1'b0);
        p0_req = 0;
        tick();
        chk1("wr_done_write", mem_write, 1'b0);
        chk1("wr_done_gnt", p0_gnt, 1'b0);

        // p1 read 0x05, requested in the IDLE cycle right after the write
        p1_req = 1; p1_we = 0; p1_addr = 8'h05; rd_val = 32'h11223344;
        tick();
        chk1("rd_p1_gnt", p1_gnt, 1'b1);
        chk1("rd_p0_gnt", p0_gnt, 1'b0);
        chk1("rd_mem_read", mem_read, 1'b1);
        chka("rd_mem_addr", mem_addr, 8'h05);
        chk1("rd_owner_issue", owner, 1'b1);
        p1_req = 0;
        tick();
        chk1("rd_wait_gnt", p1_gnt, 1'b0);
        chk1("rd_wait_read", mem_read, 1'b0);
        chk1("rd_wait_rvalid", p1_rvalid, 1'b0);
        chk1("rd_owner_wait", owner, 1'b1);
        tick();
        chk1("rd_p1_rvalid", p1_rvalid, 1'b1);
        chkd("rd_p1_rdata", p1_rdata, 32'h11223344);
        chk1("rd_p0_rvalid", p0_rvalid, 1'b0);
        chk1("rd_owner_rvalid", owner, 1'b1);
        tick();
        chk1("rd_rvalid_pulse", p1_rvalid, 1'b0);
        chkd("rd_rdata_hold", p1_rdata, 32'h11223344);
        chk1("rd_owner_idle", owner, 1'b0);

        // Both ports read continuously
        p0_req = 1; p0_we = 0; p0_addr = 8'h10;
        p1_req = 1; p1_we = 0; p1_addr = 8'h20;
        for (int i = 0; i < 4; i++) begin
`ifdef DMARB_ROUND_ROBIN_EN
            exp_w = (i % 2 == 1);
`else
            exp_w = 1'b0;
`endif
            rd_val = 32'hA0000000 + 32'(i);
            tick();
            chk1($sformatf("cont%0d_p0_gnt", i), p0_gnt, ~exp_w);
            chk1($sformatf("cont%0d_p1_gnt", i), p1_gnt, exp_w);
            chk1($sformatf("cont%0d_owner", i), owner, exp_w);
            tick();
            tick();
            chk1($sformatf("cont%0d_rvalid", i), exp_w ? p1_rvalid : p0_rvalid, 1'b1);
            chk1($sformatf("cont%0d_other_rvalid", i), exp_w ? p0_rvalid : p1_rvalid, 1'b0);
            chkd($sformatf("cont%0d_rdata", i), exp_w ? p1_rdata : p0_rdata,
                 32'hA0000000 + 32'(i));
        end
        p0_req = 0; p1_req = 0;
        tick();
        chk1("cont_end_read", mem_read, 1'b0);

        // Reset during RWAIT aborts the read
        p0_req = 1; p0_we = 0; p0_addr = 8'h30; rd_val = 32'h00000055;
        tick();
        chk1("abort_gnt", p0_gnt, 1'b1);
        p0_req = 0;
        tick();
        rst = 1;
        tick();
        chk1("abort_mem_read", mem_read, 1'b0);
        chk1("abort_rvalid", p0_rvalid, 1'b0);
        chk1("abort_owner", owner, 1'b0);
        chkd("abort_rdata", p0_rdata, 32'h0);
        rst = 0;
        p1_req = 1; p1_we = 1; p1_addr = 8'h40; p1_wdata = 32'hCAFEF00D;
        tick();
        chk1("abort_idle_gnt", p1_gnt, 1'b1);
        chk1("abort_after_rvalid", p0_rvalid, 1'b0);
        p1_req = 0;
        tick();
        chk1("abort_after_rvalid2", p0_rvalid, 1'b0);

        // Top-of-range address passes unmodified, single write pulse
        p0_req = 1; p0_we = 1; p0_addr = 8'hFF; p0_wdata = 32'h12345678;
        tick();
        chka("ff_mem_addr", mem_addr, 8'hFF);
        chk1("ff_mem_write", mem_write, 1'b1);
        p0_req = 0;
        tick();
        chk1("ff_write_pulse1", mem_write, 1'b0);
        tick();
        chk1("ff_write_pulse2", mem_write, 1'b0);
        chka("ff_addr_hold", mem_addr, 8'hFF);

        // p1 request pulsed only during RWAIT is never sampled
        p0_req = 1; p0_we = 0; p0_addr = 8'h50; rd_val = 32'h00000077;
        tick();
        chk1("pulse_p0_gnt", p0_gnt, 1'b1);
        p0_req = 0;
        tick();
        p1_req = 1; p1_we = 0; p1_addr = 8'h60;
        tick();
        p1_req = 0;
        chk1("pulse_p0_rvalid", p0_rvalid, 1'b1);
        chkd("pulse_p0_rdata", p0_rdata, 32'h00000077);
        chk1("pulse_p1_gnt_a", p1_gnt, 1'b0);
        tick();
        chk1("pulse_p1_gnt_b", p1_gnt, 1'b0);
        chk1("pulse_mem_read_b", mem_read, 1'b0);
        chk1("pulse_mem_write_b", mem_write, 1'b0);
        tick();
        chk1("pulse_p1_gnt_c", p1_gnt, 1'b0);
        chk1("pulse_mem_read_c", mem_read, 1'b0);
        chk1("pulse_p1_rvalid_c", p1_rvalid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
